// File: rtl/match_result_tx_if.sv
// Match-result transmitter bus: record input side and byte-stream output side.
interface match_result_tx_if #(
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic          frame_start;
    logic          frame_end;
    logic [59:0]   din;
    logic          din_valid;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          overflow;
    logic [LW-1:0] fifo_level;

    modport master (
        output frame_start, frame_end, din, din_valid, tx_ready,
        input  tx_data, tx_valid, busy, overflow, fifo_level
    );

    modport slave (
        input  frame_start, frame_end, din, din_valid, tx_ready,
        output tx_data, tx_valid, busy, overflow, fifo_level
    );
endinterface

// File: rtl/match_result_tx.sv
// Match-result transmitter: buffers 60-bit match records in a FIFO and streams
// each frame as sync header, 8 bytes per record, then a 16-bit record count.
module match_result_tx #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] SYNC_WORD  = 16'hA55A
) (
    input logic              clk,
    input logic              rst,
    match_result_tx_if.slave mr_if
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, HDR_HI, HDR_LO, STREAM, REC, CNT_HI, CNT_LO
    } state_t;

    state_t        state_q;
    logic [7:0]    tx_data_q;
    logic          tx_valid_q;
    logic [55:0]   sr_q;
    logic [2:0]    idx_q;
    logic [15:0]   rec_cnt_q;
    logic          end_seen_q;
    logic          overflow_q;

    logic [59:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;

    logic          active;
    logic          xfer;
    logic          full;
    logic          wr_en;
    logic          pop;
    logic [59:0]   rd_rec;

    // Handshake and FIFO control decoded from start-of-cycle state
    always_comb begin
        active  = (state_q != IDLE);
        xfer    = tx_valid_q && mr_if.tx_ready;
        full    = (level_q == DEPTH_L);
        wr_en   = active && mr_if.din_valid && !full;
        pop     = (state_q == STREAM) && (level_q != '0);
        rd_rec  = mem_q[rd_ptr_q];
        level_d = level_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Record storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_ptr_q] <= mr_if.din;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // Per-frame bookkeeping: accepted-record count, overflow and end marker
    always_ff @(posedge clk) begin
        if (rst) begin
            rec_cnt_q  <= '0;
            overflow_q <= 1'b0;
            end_seen_q <= 1'b0;
        end else if (!active) begin
            if (mr_if.frame_start) begin
                rec_cnt_q  <= '0;
                overflow_q <= 1'b0;
                end_seen_q <= 1'b0;
            end
        end else begin
            if (mr_if.frame_end) end_seen_q <= 1'b1;
            if (mr_if.din_valid) begin
                if (full) begin
                    overflow_q <= 1'b1;
                end else if (rec_cnt_q != '1) begin
                    rec_cnt_q <= rec_cnt_q + 16'd1;
                end
            end
        end
    end

    // Frame sequencer with registered byte output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            sr_q       <= '0;
            idx_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mr_if.frame_start) begin
                        state_q    <= HDR_HI;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= SYNC_WORD[15:8];
                    end
                end
                HDR_HI: begin
                    if (xfer) begin
                        state_q   <= HDR_LO;
                        tx_data_q <= SYNC_WORD[7:0];
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        state_q    <= STREAM;
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= '0;
                    end
                end
                STREAM: begin
                    if (pop) begin
                        // byte0 goes straight to the output; sr_q holds bytes 1..7
                        state_q    <= REC;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= {4'b0000, rd_rec[59:56]};
                        sr_q       <= rd_rec[55:0];
                        idx_q      <= '0;
                    end else if (end_seen_q) begin
                        state_q    <= CNT_HI;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= rec_cnt_q[15:8];
                    end
                end
                REC: begin
                    if (xfer) begin
                        if (idx_q == 3'd7) begin
                            state_q    <= STREAM;
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= '0;
                        end else begin
                            idx_q     <= idx_q + 3'd1;
                            tx_data_q <= sr_q[55:48];
                            sr_q      <= {sr_q[47:0], 8'h00};
                        end
                    end
                end
                CNT_HI: begin
                    if (xfer) begin
                        state_q   <= CNT_LO;
                        tx_data_q <= rec_cnt_q[7:0];
                    end
                end
                CNT_LO: begin
                    if (xfer) begin
                        state_q    <= IDLE;
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= '0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    tx_valid_q <= 1'b0;
                    tx_data_q  <= '0;
                end
            endcase
        end
    end

    assign mr_if.tx_data    = tx_data_q;
    assign mr_if.tx_valid   = tx_valid_q;
    assign mr_if.busy       = active;
    assign mr_if.overflow   = overflow_q;
    assign mr_if.fifo_level = level_q;

endmodule

// File: tb/tb_match_result_tx.sv
// Bench for match_result_tx: directed frames plus random records/backpressure,
// byte stream compared against a frame model built from the accepted records.
module tb_match_result_tx;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    match_result_tx_if #(.FIFO_DEPTH(DEPTH)) mif ();

    match_result_tx #(.FIFO_DEPTH(DEPTH), .SYNC_WORD(16'hA55A)) dut (
        .clk   (clk),
        .rst   (rst),
        .mr_if (mif.slave)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  got_q [$];
    logic [7:0]  exp_q [$];
    logic [59:0] acc_q [$];
    bit          rand_ready = 1'b0;
    bit          stall_prev = 1'b0;
    logic [7:0]  data_prev  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte collector and hold-stability watcher
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && mif.tx_valid)
                chk("hold_stable", 64'(mif.tx_data), 64'(data_prev));
            if (mif.tx_valid && mif.tx_ready)
                got_q.push_back(mif.tx_data);
            stall_prev = mif.tx_valid && !mif.tx_ready;
            data_prev  = mif.tx_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) mif.tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [59:0] rec);
        mif.din       = rec;
        mif.din_valid = 1'b1;
        step();
        mif.din_valid = 1'b0;
    endtask

    task automatic start_frame();
        got_q.delete();
        acc_q.delete();
        mif.frame_start = 1'b1;
        step();
        mif.frame_start = 1'b0;
        chk("first_valid", 64'(mif.tx_valid), 64'd1);
        chk("first_byte",  64'(mif.tx_data),  64'hA5);
    endtask

    task automatic end_frame();
        mif.frame_end = 1'b1;
        step();
        mif.frame_end = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (mif.busy && n < 2000) begin
            step();
            n++;
        end
        chk({tag, "_idle"}, 64'(mif.busy), 64'd0);
    endtask

    // Expected frame: header, each accepted record as 8 bytes MSB first, count
    function automatic void build_exp();
        logic [63:0] w;
        int unsigned cnt;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        foreach (acc_q[i]) begin
            w = {4'b0000, acc_q[i]};
            for (int b = 7; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
        end
        cnt = (acc_q.size() > 65535) ? 65535 : acc_q.size();
        exp_q.push_back(8'(cnt >> 8));
        exp_q.push_back(8'(cnt));
    endfunction

    task automatic compare_frame(input string tag);
        int n;
        build_exp();
        chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_b%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    function automatic logic [59:0] rnd_rec();
        return 60'({$urandom(), $urandom()});
    endfunction

    initial begin
        logic [59:0] r;
        int          nrec;

        rst             = 1'b1;
        mif.frame_start = 1'b0;
        mif.frame_end   = 1'b0;
        mif.din         = '0;
        mif.din_valid   = 1'b0;
        mif.tx_ready    = 1'b1;
        steps(3);

        // Reset values, and reset dominating a same-cycle start/write
        chk("rst_tx_valid", 64'(mif.tx_valid),   64'd0);
        chk("rst_tx_data",  64'(mif.tx_data),    64'd0);
        chk("rst_busy",     64'(mif.busy),       64'd0);
        chk("rst_overflow", 64'(mif.overflow),   64'd0);
        chk("rst_level",    64'(mif.fifo_level), 64'd0);
        mif.frame_start = 1'b1;
        mif.din_valid   = 1'b1;
        step();
        mif.frame_start = 1'b0;
        mif.din_valid   = 1'b0;
        chk("rst_prio_busy",  64'(mif.busy),       64'd0);
        chk("rst_prio_level", 64'(mif.fifo_level), 64'd0);
        rst = 1'b0;
        step();

        // Records while idle are discarded silently
        push(rnd_rec());
        step();
        chk("idle_din_level",    64'(mif.fifo_level), 64'd0);
        chk("idle_din_overflow", 64'(mif.overflow),   64'd0);

        // Empty frame
        start_frame();
        steps(3);
        end_frame();
        wait_idle("empty");
        step();
        compare_frame("empty");

        // Single known record
        start_frame();
        acc_q.push_back(60'h123456789ABCDEF);
        push(60'h123456789ABCDEF);
        step();
        end_frame();
        wait_idle("one");
        step();
        compare_frame("one");
        chk("one_overflow", 64'(mif.overflow), 64'd0);

        // Three records queued when frame_end arrives
        start_frame();
        for (int i = 0; i < 3; i++) begin
            r = rnd_rec();
            acc_q.push_back(r);
            push(r);
        end
        end_frame();
        wait_idle("three");
        step();
        compare_frame("three");

        // Sink stalled mid-record while 17 records arrive into an empty FIFO
        start_frame();
        r = rnd_rec();
        acc_q.push_back(r);
        push(r);
        steps(2);
        mif.tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            r = rnd_rec();
            if (i < 16) acc_q.push_back(r);
            push(r);
        end
        steps(3);
        chk("ovf_flag",  64'(mif.overflow),   64'd1);
        chk("ovf_level", 64'(mif.fifo_level), 64'd16);
        mif.tx_ready = 1'b1;
        end_frame();
        wait_idle("ovf");
        step();
        compare_frame("ovf");
        chk("ovf_sticky", 64'(mif.overflow), 64'd1);

        // Random records with random backpressure
        rand_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            start_frame();
            chk("ovf_cleared", 64'(mif.overflow), 64'd0);
            nrec = $urandom_range(1, 8);
            for (int i = 0; i < nrec; i++) begin
                r = rnd_rec();
                acc_q.push_back(r);
                push(r);
                steps($urandom_range(0, 3));
            end
            end_frame();
            wait_idle($sformatf("rnd%0d", f));
            step();
            compare_frame($sformatf("rnd%0d", f));
        end
        rand_ready   = 1'b0;
        mif.tx_ready = 1'b1;
        step();

        // Reset while byte 4 of a record is presented
        start_frame();
        r = rnd_rec();
        push(r);
        begin
            int n = 0;
            while (got_q.size() < 6 && n < 200) begin
                step();
                n++;
            end
            chk("abort_reached_b4", 64'(got_q.size()), 64'd6);
        end
        rst = 1'b1;
        step();
        chk("abort_tx_valid", 64'(mif.tx_valid),   64'd0);
        chk("abort_tx_data",  64'(mif.tx_data),    64'd0);
        chk("abort_busy",     64'(mif.busy),       64'd0);
        chk("abort_overflow", 64'(mif.overflow),   64'd0);
        chk("abort_level",    64'(mif.fifo_level), 64'd0);
        rst = 1'b0;
        got_q.delete();
        steps(5);
        chk("abort_no_trailer", 64'(got_q.size()), 64'd0);

        start_frame();
        for (int i = 0; i < 2; i++) begin
            r = rnd_rec();
            acc_q.push_back(r);
            push(r);
        end
        end_frame();
        wait_idle("after_rst");
        step();
        compare_frame("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/match_result_tx.md
MATCH_RESULT_TX -- requirements
Module: match_result_tx

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, meaning record FIFO depth (power of two, 4..64).
REQ-002 The block SHALL have parameter SYNC_WORD, default 16'hA55A, meaning frame header, sent MSB byte first.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-005 The block SHALL have port frame_start, input, width 1: one-cycle pulse that opens a frame (same pulse as the matcher start).
REQ-006 The block SHALL have port frame_end, input, width 1: one-cycle pulse meaning the matcher has finished the frame.
REQ-007 The block SHALL have port din, input, width 60: match record {coor_LR[59:40], coor_P[39:20], coor_Main[19:0]}.
REQ-008 The block SHALL have port din_valid, input, width 1: din is valid this cycle; there is no backpressure toward the source.
REQ-009 The block SHALL have port tx_data, output, width 8: serial byte out.
REQ-010 The block SHALL have port tx_valid, output, width 1: tx_data is valid.
REQ-011 The block SHALL have port tx_ready, input, width 1: the sink accepts the byte; a transfer occurs when tx_valid && tx_ready.
REQ-012 The block SHALL have port busy, output, width 1: high whenever the state is not IDLE.
REQ-013 The block SHALL have port overflow, output, width 1: sticky; a record was dropped in the current frame.
REQ-014 The block SHALL have port fifo_level, output, width log2(FIFO_DEPTH)+1: current FIFO occupancy.

Function
REQ-015 The state machine SHALL have the states IDLE, HDR_HI, HDR_LO, STREAM, REC, CNT_HI, CNT_LO.
REQ-016 In IDLE, frame_start SHALL cause the next state to be HDR_HI, clear overflow and rec_cnt, and clear end_seen; frame_start in any other state SHALL be ignored.
REQ-017 HDR_HI SHALL present SYNC_WORD[15:8] and HDR_LO SHALL present SYNC_WORD[7:0]; each state SHALL advance only on a transfer.
REQ-018 In STREAM, if the FIFO is non-empty the block SHALL pop one record into a 64-bit shift register ({4'b0, record}) and go to REC; otherwise, if end_seen is set, it SHALL go to CNT_HI; otherwise it SHALL remain in STREAM.
REQ-019 REC SHALL emit 8 bytes MSB first (byte0 = {4'b0, rec[59:56]}, byte7 = rec[7:0]), advance one byte per transfer, and return to STREAM after byte 7.
REQ-020 CNT_HI SHALL present rec_cnt[15:8] and CNT_LO SHALL present rec_cnt[7:0]; after the CNT_LO transfer the state SHALL be IDLE.
REQ-021 tx_valid SHALL be high only in HDR_HI, HDR_LO, REC, CNT_HI and CNT_LO.
REQ-022 tx_data SHALL stay stable while tx_valid && !tx_ready.
REQ-023 A frame_end pulse in any non-IDLE state SHALL set end_seen, including in the same cycle as a transfer or pop; frame_end in IDLE SHALL be ignored.
REQ-024 A din_valid in a non-IDLE state SHALL write din to the FIFO if occupancy < FIFO_DEPTH and increment rec_cnt (16-bit, saturating at 16'hFFFF).
REQ-025 If the FIFO is full, din SHALL be dropped and overflow set; the decision uses occupancy at the start of the cycle, so a same-cycle pop does not make room.
REQ-026 din_valid in IDLE, including the frame_start cycle itself, SHALL be discarded without setting overflow.
REQ-027 A simultaneous write and pop SHALL leave fifo_level unchanged.
REQ-028 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 A written record SHALL be poppable no earlier than the cycle after its write.
REQ-030 From frame_start with tx_ready held high, the first tx_valid SHALL occur in the next cycle.
REQ-031 The trailer SHALL follow the last record byte only after the FIFO is empty and end_seen is set.

Reset
REQ-032 While rst is high, the block SHALL set state=IDLE, tx_valid=0, tx_data=0, busy=0, overflow=0, fifo_level=0, rec_cnt=0, end_seen=0, and empty the FIFO pointers.
REQ-033 rst asserted mid-frame SHALL abort the frame immediately; no trailer SHALL be sent, and the next frame SHALL start only on a new frame_start.
REQ-034 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-035 Scenario: frame_start, no records, frame_end at cycle 5, tx_ready=1 -> bytes A5 5A 00 00, then busy=0.
REQ-036 Scenario: frame_start, one record din=60'h123456789ABCDEF, frame_end -> A5 5A 01 23 45 67 89 AB CD EF 00 01.
REQ-037 Scenario: tx_ready=0 for 20 cycles mid-record with 17 din_valid pulses, FIFO_DEPTH=16 -> overflow=1 and fifo_level=16; trailer count is accepted records only, with no byte duplicated or lost.
REQ-038 Scenario: frame_end arrives while 3 records are still queued -> all 24 record bytes precede the trailer 00 03.
REQ-039 Scenario: tx_ready toggled randomly -> tx_data is stable whenever tx_valid && !tx_ready, and the byte stream equals the golden model.
REQ-040 Scenario: rst pulsed during REC byte 4 -> outputs are at reset values the next cycle; a subsequent frame starts with A5 and has a correct count.
